// File: rtl/n8_controller.sv
// Serial front end for the N8 game controller: strobes latch, clocks out 8 bits,
// and presents the buttons as active-high levels updated once per poll frame.
module n8_controller #(
  parameter int unsigned CLK_DIV    = 300,
  parameter int unsigned POLL_TICKS = 2750
) (
  input  logic clk,
  input  logic reset_n,
  input  logic nes_data,
  output logic nes_latch,
  output logic nes_pulse,
  output logic a,
  output logic b,
  output logic select,
  output logic start,
  output logic up,
  output logic down,
  output logic left,
  output logic right,
  output logic frame_valid
);

  localparam int unsigned DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned IDLE_W = (POLL_TICKS > 1) ? $clog2(POLL_TICKS) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(POLL_TICKS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_PULSE_HI,
    ST_PULSE_LO,
    ST_UPDATE
  } state_e;

  state_e              state_q,    state_d;
  logic                sync1_q,    sync1_d;
  logic                sync2_q,    sync2_d;
  logic [DIV_W-1:0]    div_cnt_q,  div_cnt_d;
  logic [IDLE_W-1:0]   idle_cnt_q, idle_cnt_d;
  logic                sub_q,      sub_d;
  logic [2:0]          bit_idx_q,  bit_idx_d;
  logic [7:0]          shift_q,    shift_d;
  logic [7:0]          btn_q,      btn_d;
  logic                latch_q,    latch_d;
  logic                pulse_q,    pulse_d;
  logic                fv_q,       fv_d;
  logic                tick;
  logic                pressed;

  // Next-state and registered-output logic
  always_comb begin
    sync1_d    = nes_data;
    sync2_d    = sync1_q;
    tick       = (div_cnt_q == DIV_LAST);
    div_cnt_d  = tick ? '0 : div_cnt_q + DIV_W'(1);
    pressed    = ~sync2_q;
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    sub_d      = sub_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    btn_d      = btn_q;
    latch_d    = latch_q;
    pulse_d    = pulse_q;
    fv_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (tick) begin
          if (idle_cnt_q == IDLE_LAST) begin
            idle_cnt_d = '0;
            latch_d    = 1'b1;
            state_d    = ST_LATCH;
          end else begin
            idle_cnt_d = idle_cnt_q + IDLE_W'(1);
          end
        end
      end
      ST_LATCH: begin
        if (tick) begin
          if (sub_q) begin
            sub_d      = 1'b0;
            latch_d    = 1'b0;
            shift_d[0] = pressed;
            bit_idx_d  = 3'd1;
            pulse_d    = 1'b1;
            state_d    = ST_PULSE_HI;
          end else begin
            sub_d = 1'b1;
          end
        end
      end
      // Sample where the pulse high level ends, so data has settled a full tick
      ST_PULSE_HI: begin
        if (tick) begin
          pulse_d            = 1'b0;
          shift_d[bit_idx_q] = pressed;
          state_d            = ST_PULSE_LO;
        end
      end
      ST_PULSE_LO: begin
        if (tick) begin
          if (bit_idx_q == 3'd7) begin
            state_d = ST_UPDATE;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            pulse_d   = 1'b1;
            state_d   = ST_PULSE_HI;
          end
        end
      end
      ST_UPDATE: begin
        btn_d   = shift_q;
        fv_d    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      div_cnt_q  <= '0;
      idle_cnt_q <= '0;
      sub_q      <= 1'b0;
      bit_idx_q  <= 3'd0;
      shift_q    <= 8'd0;
      btn_q      <= 8'd0;
      latch_q    <= 1'b0;
      pulse_q    <= 1'b0;
      fv_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      div_cnt_q  <= div_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      sub_q      <= sub_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      btn_q      <= btn_d;
      latch_q    <= latch_d;
      pulse_q    <= pulse_d;
      fv_q       <= fv_d;
    end
  end

  assign nes_latch   = latch_q;
  assign nes_pulse   = pulse_q;
  assign frame_valid = fv_q;
  assign a           = btn_q[0];
  assign b           = btn_q[1];
  assign select      = btn_q[2];
  assign start       = btn_q[3];
  assign up          = btn_q[4];
  assign down        = btn_q[5];
  assign left        = btn_q[6];
  assign right       = btn_q[7];

endmodule
